// File: rtl/stdout_uart_tx.sv
// Byte FIFO plus 8N1 UART transmitter (LSB first, idle high) fed by the CPU stdout strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module stdout_uart_tx #(
   parameter int UART_TX_BAUD    = 1,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] stdout,
   input  logic       stdout_en,
   output logic       stdout_full,
   output logic       tx_busy,
   output logic       overflow,
   output logic       uart_tx_pin
);

   localparam int AW = FIFO_DEPTH_LOG2;
   localparam int CW = FIFO_DEPTH_LOG2 + 1;
   localparam int BW = (UART_TX_BAUD > 1) ? $clog2(UART_TX_BAUD) : 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(1 << FIFO_DEPTH_LOG2);
   localparam logic [BW-1:0] BAUD_MAX  = BW'(UART_TX_BAUD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_TX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   logic [7:0]    r_mem [2**AW];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   state_t        r_state, w_state_next;
   logic [BW-1:0] r_baud, w_baud_next;
   logic [2:0]    r_idx, w_idx_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          r_pin, w_pin_next;
   logic          r_parity;

   logic          w_full, w_push, w_pop, w_bit_end;
   logic [7:0]    w_head;

   assign w_full      = (r_count == DEPTH_CNT);
   assign w_head      = r_mem[r_rd_ptr];
   // A pop frees a slot in the same cycle, so a write into a full FIFO is still accepted then.
   assign w_push      = stdout_en && (!w_full || w_pop);
   assign w_bit_end   = (r_baud == BAUD_MAX);

   assign stdout_full = w_full;
   assign overflow    = r_overflow;
   assign tx_busy     = (r_count != '0) || (r_state != S_IDLE);
   assign uart_tx_pin = r_pin;

   // NOTE: the storage array carries no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= stdout;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (stdout_en && !w_push) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_pin    <= 1'b1;
         r_parity <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_idx   <= w_idx_next;
         r_shift <= w_shift_next;
         r_pin   <= w_pin_next;
         if (w_pop) r_parity <= ^w_head;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_baud_next  = (r_state == S_IDLE || w_bit_end) ? '0 : r_baud + BW'(1);

      unique case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_shift_next = w_head;
               w_idx_next   = '0;
               w_baud_next  = '0;
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_idx_next   = '0;
               w_state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_shift_next = r_shift >> 1;
               w_idx_next   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) w_state_next = S_STOP;
         end
`endif
         S_STOP: begin
            // Back-to-back frames: the next byte is popped straight into START with no idle gap.
            if (w_bit_end) begin
               if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_shift_next = w_head;
                  w_idx_next   = '0;
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // The pin is registered from the next state so it changes exactly on the bit boundary.
      unique case (w_state_next)
         S_START:  w_pin_next = 1'b0;
         S_DATA:   w_pin_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_pin_next = r_parity;
`endif
         default:  w_pin_next = 1'b1;
      endcase
   end

endmodule

// File: doc/stdout_uart_tx.md
Name: stdout_uart_tx

Overview:
- Downstream stage of the brainfuck CPU core; consumes its `stdout`/`stdout_en` byte strobe and serialises it onto `uart_tx_pin`.
- Contains a byte FIFO to absorb CPU output bursts and an 8N1 UART transmitter, LSB first, idle high.
- Drives `stdout_full` back to the CPU so the core stalls `.` instructions instead of losing characters.

Parameters:
- UART_TX_BAUD, 1: clk cycles per UART bit. Legal range ≥1; 1 is the fast simulation setting.
- FIFO_DEPTH_LOG2, 4: FIFO depth = 2**FIFO_DEPTH_LOG2 bytes (default 16).

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous reset, active-high.
- stdout  in  8: byte from CPU.
- stdout_en  in  1: one-cycle write strobe, sampled on rising clk.
- stdout_full  out  1: FIFO holds 2**FIFO_DEPTH_LOG2 bytes.
- tx_busy  out  1: FIFO non-empty or frame in progress.
- overflow  out  1: sticky; a write was dropped.
- uart_tx_pin  out  1: serial output.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - uart_tx_pin=1, stdout_full=0, tx_busy=0, overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; baud counter = 0.
  - Any partial frame is abandoned.
- FIFO:
  - Registered count of width FIFO_DEPTH_LOG2+1; pointers wrap modulo depth.
  - Write when stdout_en=1 and (not full, or pop in same cycle).
  - stdout_en=1 while full with no pop in that cycle: byte dropped and overflow←1. Only reset clears overflow.
  - stdout_full is combinational from count (count==depth).
  - Pop is only possible when count>0, so empty-state write plus pop never coincide.
- TX FSM states: IDLE, START, DATA, STOP.
  - Baud counter counts 0..UART_TX_BAUD-1 in every non-IDLE state; a bit ends when the counter reaches UART_TX_BAUD-1.
  - IDLE: pin=1. If count>0: pop the head into the shift register, clear the baud counter, go to START.
  - START: pin=0 for UART_TX_BAUD cycles, then DATA with bit index 0.
  - DATA: pin=shift[0] for UART_TX_BAUD cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: pin=1 for UART_TX_BAUD cycles. At the end of the bit, if count>0, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- Latency and frame length:
  - Write at edge N into an empty FIFO with FSM in IDLE → pop at edge N+1 → pin low from N+1.
  - Frame = 10·UART_TX_BAUD cycles.
- uart_tx_pin is registered (glitch-free).
- tx_busy = (count>0) | (state≠IDLE).

Optional Feature:
- UART_TX_PARITY_EN defined: adds a PARITY state between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for UART_TX_BAUD cycles.
  - Frame becomes 11·UART_TX_BAUD cycles.
- Undefined: plain 8N1, 10·UART_TX_BAUD cycles, no PARITY state.

Test Plan:
- Reset, then idle 50 cycles → uart_tx_pin=1, tx_busy=0, stdout_full=0, overflow=0.
- UART_TX_BAUD=4, write 0x41 at edge 0 → pin low for edges 1–4, then data bits 1,0,0,0,0,0,1,0 (4 cycles each), stop high 4 cycles, tx_busy falls at edge 41.
- UART_TX_BAUD=1, write 0x48, 0x69 on consecutive cycles → 20 contiguous bit times, stop of 'H' followed immediately by start of 'i'. Receiver model decodes "Hi".
- UART_TX_BAUD=4, depth 16, 18 writes on consecutive edges 0–17:
  - stdout_full=1 after edge 16.
  - Byte 17 dropped, overflow=1.
  - Bytes 0–16 appear in order on the line.
- Assert rst mid-DATA of 0x55 → pin=1 immediately (before next clk edge). FIFO empty; after release no frame until the next write.
- UART_TX_PARITY_EN, UART_TX_BAUD=2, write 0x07 → parity bit=1 at bit-time 9, stop at bit-time 10, frame length 22 cycles.
